// File: rtl/ps2_scancode_decoder_if.sv
// PS/2 pin pair plus decoded key-event bus between the decoder and the key-state bank.
interface ps2_scancode_decoder_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keyCode;
   logic       press;
   logic       extended;
   logic       valid;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  keyCode, press, extended, valid, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output keyCode, press, extended, valid, frame_err
   );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code receiver and prefix decoder producing held key events.
// Optional PS2_PARITY_CHECK_EN: when defined, odd-parity mismatches drop the frame.
//
// state  | meaning
// IDLE   | waiting for a start bit (data=0 on a falling edge)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | consuming the parity bit
// STOP   | checking stop bit, then decoding the byte or flagging an error
module ps2_scancode_decoder #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input logic                   Clk,
   input logic                   Reset,
   ps2_scancode_decoder_if.slave bus
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

   rx_state_t       state;
   logic            clk_s1, clk_s2, clk_h;
   logic            data_s1, data_s2;
   logic [7:0]      shift;
   logic [2:0]      bit_cnt;
   logic [WD_W-1:0] wdog;
   logic            brk, ext;
   logic [7:0]      key_code_q;
   logic            press_q, ext_q, valid_q, frame_err_q;
   logic            fall;
   logic            frame_good;
`ifdef PS2_PARITY_CHECK_EN
   logic            parity_bit;
`endif

   assign fall = clk_h & ~clk_s2;

`ifdef PS2_PARITY_CHECK_EN
   assign frame_good = data_s2 & (^{shift, parity_bit});
`else
   assign frame_good = data_s2;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= IDLE;
         clk_s1      <= 1'b1;
         clk_s2      <= 1'b1;
         clk_h       <= 1'b1;
         data_s1     <= 1'b1;
         data_s2     <= 1'b1;
         shift       <= 8'h00;
         bit_cnt     <= 3'd0;
         wdog        <= '0;
         brk         <= 1'b0;
         ext         <= 1'b0;
         key_code_q  <= 8'h00;
         press_q     <= 1'b0;
         ext_q       <= 1'b0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_bit  <= 1'b0;
`endif
      end else begin
         clk_s1      <= bus.ps2_clk;
         clk_s2      <= clk_s1;
         clk_h       <= clk_s2;
         data_s1     <= bus.ps2_data;
         data_s2     <= data_s1;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;

         // Watchdog abandons a stalled frame silently; prefix flags are kept.
         if (fall) begin
            wdog <= WD_RELOAD;
         end else if (state != IDLE) begin
            if (wdog == '0) state <= IDLE;
            else            wdog  <= wdog - 1'b1;
         end

         if (fall) begin
            case (state)
               IDLE: begin
                  if (!data_s2) begin
                     shift   <= 8'h00;
                     bit_cnt <= 3'd0;
                     state   <= DATA;
                  end
               end
               DATA: begin
                  shift <= {data_s2, shift[7:1]};
                  if (bit_cnt == 3'd7) state <= PARITY;
                  bit_cnt <= bit_cnt + 3'd1;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  parity_bit <= data_s2;
`endif
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (frame_good) begin
                     case (shift)
                        8'hE0: ext <= 1'b1;
                        8'hF0: brk <= 1'b1;
                        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                           brk <= 1'b0;
                           ext <= 1'b0;
                        end
                        default: begin
                           key_code_q <= shift;
                           press_q    <= ~brk;
                           ext_q      <= ext;
                           valid_q    <= 1'b1;
                           brk        <= 1'b0;
                           ext        <= 1'b0;
                        end
                     endcase
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.keyCode   = key_code_q;
   assign bus.press     = press_q;
   assign bus.extended  = ext_q;
   assign bus.valid     = valid_q;
   assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench: PS/2 frames driven bit by bit, expected events scoreboarded.
module tb_ps2_scancode_decoder;

   localparam int TIMEOUT = 200;
   localparam int HALF    = 20;

   typedef struct packed {
      logic       err;
      logic [7:0] code;
      logic       press;
      logic       ext;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   logic prev_pulse = 1'b0;

   ps2_scancode_decoder_if bus();

   ps2_scancode_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   always @(negedge Clk) begin
      exp_t e;
      if (!Reset && (bus.valid || bus.frame_err)) begin
         checks++;
         if (bus.valid && bus.frame_err) begin
            failures++;
            $display("FAIL pulse_overlap: valid=%0b frame_err=%0b, required not both", bus.valid, bus.frame_err);
         end
         checks++;
         if (prev_pulse) begin
            failures++;
            $display("FAIL pulse_width: pulse high 2 cycles in a row, required 1 cycle");
         end
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b code=%02h, required none", bus.valid, bus.frame_err, bus.keyCode);
         end else begin
            e = sb.pop_front();
            checks++;
            if ({bus.frame_err, bus.valid} !== {e.err, ~e.err}) begin
               failures++;
               $display("FAIL event_kind: frame_err=%0b valid=%0b, required frame_err=%0b valid=%0b", bus.frame_err, bus.valid, e.err, ~e.err);
            end else if (!e.err) begin
               checks++;
               if ({bus.keyCode, bus.press, bus.extended} !== {e.code, e.press, e.ext}) begin
                  failures++;
                  $display("FAIL event_fields: code=%02h press=%0b ext=%0b, required code=%02h press=%0b ext=%0b", bus.keyCode, bus.press, bus.extended, e.code, e.press, e.ext);
               end
            end
         end
      end
      prev_pulse = bus.valid | bus.frame_err;
   end

   task automatic push_key(input logic [7:0] code, input logic press, input logic ext);
      exp_t e;
      e.err = 1'b0; e.code = code; e.press = press; e.ext = ext;
      sb.push_back(e);
   endtask

   task automatic push_err();
      exp_t e;
      e.err = 1'b1; e.code = 8'h00; e.press = 1'b0; e.ext = 1'b0;
      sb.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_parity, input logic stop_bit, input int nbits);
      logic [10:0] f;
      f = {stop_bit, (~^b) ^ bad_parity, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data = f[i];
         repeat (HALF) @(negedge Clk);
         bus.ps2_clk = 1'b0;
         repeat (HALF) @(negedge Clk);
         bus.ps2_clk = 1'b1;
      end
      bus.ps2_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 11);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge Clk);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: %0d events outstanding, required 0", name, sb.size());
         sb.delete();
      end
      repeat (10) @(negedge Clk);
   endtask

   task automatic check_outputs(input string name, input logic [7:0] code, input logic press, input logic ext);
      checks++;
      if ({bus.keyCode, bus.press, bus.extended, bus.valid, bus.frame_err} !== {code, press, ext, 2'b00}) begin
         failures++;
         $display("FAIL %s: code=%02h press=%0b ext=%0b valid=%0b err=%0b, required code=%02h press=%0b ext=%0b valid=0 err=0",
                  name, bus.keyCode, bus.press, bus.extended, bus.valid, bus.frame_err, code, press, ext);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (4) @(negedge Clk);
      check_outputs("reset_during", 8'h00, 1'b0, 1'b0);
      Reset = 1'b0;
      repeat (10) @(negedge Clk);
      check_outputs("reset_after", 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_make();
      push_key(8'h1D, 1'b1, 1'b0);
      send(8'h1D);
      wait_drain("make");
      repeat (50) @(negedge Clk);
      check_outputs("make_held", 8'h1D, 1'b1, 1'b0);
   endtask

   task automatic test_break();
      send(8'hF0);
      push_key(8'h1D, 1'b0, 1'b0);
      send(8'h1D);
      wait_drain("break");
      check_outputs("break_held", 8'h1D, 1'b0, 1'b0);
   endtask

   task automatic test_extended();
      send(8'hE0);
      send(8'hF0);
      push_key(8'h75, 1'b0, 1'b1);
      send(8'h75);
      wait_drain("ext_break");
      check_outputs("ext_break_held", 8'h75, 1'b0, 1'b1);
      push_key(8'h1C, 1'b1, 1'b0);
      send(8'h1C);
      wait_drain("after_ext");
      send(8'hE0);
      push_key(8'h74, 1'b1, 1'b1);
      send(8'h74);
      wait_drain("ext_make");
   endtask

   task automatic test_discard();
      send(8'hE0);
      send(8'hF0);
      send(8'hAA);
      push_key(8'h2B, 1'b1, 1'b0);
      send(8'h2B);
      wait_drain("discard_clears");
      send(8'hFA);
      check_outputs("discard_no_event", 8'h2B, 1'b1, 1'b0);
   endtask

   task automatic test_frame_errors();
`ifdef PS2_PARITY_CHECK_EN
      push_err();
      send_frame(8'h23, 1'b1, 1'b1, 11);
      wait_drain("parity_err");
      check_outputs("parity_err_held", 8'h2B, 1'b1, 1'b0);
`else
      push_key(8'h23, 1'b1, 1'b0);
      send_frame(8'h23, 1'b1, 1'b1, 11);
      wait_drain("parity_ignored");
`endif
      send(8'hF0);
      push_err();
      send_frame(8'h2A, 1'b0, 1'b0, 11);
      wait_drain("stop_err");
      push_key(8'h2A, 1'b0, 1'b0);
      send(8'h2A);
      wait_drain("err_keeps_flags");
   endtask

   task automatic test_timeout();
      send_frame(8'h55, 1'b0, 1'b1, 5);
      repeat (TIMEOUT + 10) @(negedge Clk);
      push_key(8'h1B, 1'b1, 1'b0);
      send(8'h1B);
      wait_drain("timeout");
   endtask

   task automatic test_reset_mid();
      send(8'hF0);
      send_frame(8'h3C, 1'b0, 1'b1, 4);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check_outputs("reset_mid", 8'h00, 1'b0, 1'b0);
      repeat (HALF * 6) @(negedge Clk);
      push_key(8'h1D, 1'b1, 1'b0);
      send(8'h1D);
      wait_drain("reset_clears_brk");
   endtask

   task automatic test_back_to_back();
      push_key(8'h16, 1'b1, 1'b0);
      send(8'h16);
      push_key(8'h1E, 1'b1, 1'b0);
      send(8'h1E);
      push_key(8'h26, 1'b1, 1'b0);
      send(8'h26);
      wait_drain("back_to_back");
   endtask

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      Reset        = 1'b1;
      test_reset();
      test_make();
      test_break();
      test_extended();
      test_discard();
      test_frame_errors();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
